// File: rtl/out_sched_pkg.sv
// Shared constants for the output packet scheduler: header magic/type words,
// event-type encoding and FSM state encoding.
package out_sched_pkg;

   // Header word 0 / word 1 values per packet kind
   localparam logic [15:0] MAGIC_NOTIF = 16'hC0DE;
   localparam logic [15:0] MAGIC_FULL  = 16'hDA7A;
   localparam logic [15:0] TYPE_NOTIF  = 16'h0001;
   localparam logic [15:0] TYPE_FULL   = 16'h0002;

   // Event type bit stored at the top of each queue entry
   localparam logic EV_NOTIF = 1'b0;
   localparam logic EV_FULL  = 1'b1;

   // Index of the final header word (six words, 0..5)
   localparam logic [2:0] HDR_LAST_IDX = 3'd5;

   // FSM state encoding
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_HDR     = 3'd1;
   localparam logic [2:0] ST_RD_REQ  = 3'd2;
   localparam logic [2:0] ST_RD_WAIT = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_HDR     = ST_HDR,
      S_RD_REQ  = ST_RD_REQ,
      S_RD_WAIT = ST_RD_WAIT,
      S_DONE    = ST_DONE
   } state_e;

endpackage

// File: rtl/out_evq_fifo.sv
// Event queue: synchronous FIFO with a two-entry write port.
// Port 0 is written ahead of port 1 when both are accepted. When only one
// slot is available, port 1 wins and port 0 is dropped. A same-cycle read
// frees its slot for the writes of that cycle. Any drop sets a sticky flag.
module out_evq_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr0_en_i,
   input  logic [DW-1:0]              wr0_data_i,
   input  logic                       wr1_en_i,
   input  logic [DW-1:0]              wr1_data_i,
   input  logic                       rd_en_i,
   output logic [DW-1:0]              rd_data_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q, wp1;
   logic [LW-1:0] lvl_q;
   logic          ovf_q;
   logic [LW:0]   n_free;
   logic          rd_ok, acc0, acc1;

   // Slot accounting and acceptance of each write port
   always_comb begin
      rd_ok  = rd_en_i && (lvl_q != '0);
      n_free = (LW+1)'(DEPTH) - {1'b0, lvl_q} + {{LW{1'b0}}, rd_ok};
      acc1   = wr1_en_i && (n_free != '0);
      acc0   = wr0_en_i && (n_free >= (acc1 ? (LW+1)'(2) : (LW+1)'(1)));
      wp1    = acc0 ? (wp_q + AW'(1)) : wp_q;
   end

   // Storage array, no reset needed (guarded by level)
   always_ff @(posedge clk) begin
      if (acc0) mem_q[wp_q] <= wr0_data_i;
      if (acc1) mem_q[wp1]  <= wr1_data_i;
   end

   // Pointers, occupancy and sticky overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q  <= '0;
         rp_q  <= '0;
         lvl_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wp_q  <= wp_q + AW'(acc0) + AW'(acc1);
         rp_q  <= rp_q + AW'(rd_ok);
         lvl_q <= lvl_q + LW'(acc0) + LW'(acc1) - LW'(rd_ok);
         if ((wr0_en_i && !acc0) || (wr1_en_i && !acc1)) ovf_q <= 1'b1;
      end
   end

   assign rd_data_o  = mem_q[rp_q];
   assign level_o    = lvl_q;
   assign overflow_o = ovf_q;

endmodule

// File: rtl/output_packet_scheduler.sv
// Output packet scheduler: queues batch/layer completion events, streams a
// six-word header per event and, for full-data packets, issues one BRAM read
// request and waits for the parser to finish.
// Optional read_done watchdog enabled by defining OUT_SCHED_TIMEOUT_EN.
module output_packet_scheduler
   import out_sched_pkg::*;
#(
   parameter int NUM_BRAM    = 8,
   parameter int BRAM_DEPTH  = 512,
   parameter int BATCH_W     = 3,
   parameter int LAYER_W     = 2,
   parameter int EVQ_DEPTH   = 4,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         batch_complete,
   input  logic [BATCH_W-1:0]           current_batch_id,
   input  logic                         all_batches_done,
   input  logic [LAYER_W-1:0]           completed_layer_id,
   output logic [15:0]                  hdr_data,
   output logic                         hdr_valid,
   input  logic                         hdr_ready,
   output logic                         hdr_last,
   output logic                         trigger_read,
   output logic [3:0]                   rd_bram_start,
   output logic [3:0]                   rd_bram_end,
   output logic [15:0]                  rd_addr_count,
   input  logic                         read_done,
   output logic                         transmission_active,
   output logic                         evq_overflow,
   output logic [$clog2(EVQ_DEPTH):0]   evq_level,
   output logic                         rd_timeout
);

   localparam int ID_W  = (BATCH_W > LAYER_W) ? BATCH_W : LAYER_W;
   localparam int EV_W  = ID_W + 1;
   localparam int LVL_W = $clog2(EVQ_DEPTH) + 1;
   localparam logic [15:0] FULL_WORDS = 16'(NUM_BRAM * BRAM_DEPTH);

   // Elaboration-time parameter sanity
   if (NUM_BRAM < 1 || NUM_BRAM > 16) begin : g_bad_nbram
      $error("NUM_BRAM must be 1..16");
   end
   if (NUM_BRAM * BRAM_DEPTH > 65535) begin : g_bad_size
      $error("NUM_BRAM*BRAM_DEPTH must fit 16 bits");
   end
   if (EVQ_DEPTH < 2 || (EVQ_DEPTH & (EVQ_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("EVQ_DEPTH must be a power of 2, >= 2");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_tmo
      $error("TIMEOUT_CYC must be >= 1");
   end

   state_e          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [15:0]     seq_q, seq_d;
   logic            type_q;
   logic [ID_W-1:0] id_q;
   logic [LVL_W-1:0] lvl_q;
   logic            deq, tmo_hit;
   logic [EV_W-1:0] nf_ev, fl_ev, head_ev;

   assign nf_ev = {EV_NOTIF, ID_W'(current_batch_id)};
   assign fl_ev = {EV_FULL,  ID_W'(completed_layer_id)};

   // Simultaneous events: NOTIF on port 0 (stored first), FULL on port 1
   out_evq_fifo #(.DEPTH(EVQ_DEPTH), .DW(EV_W)) u_evq (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr0_en_i   (batch_complete),
      .wr0_data_i (nf_ev),
      .wr1_en_i   (all_batches_done),
      .wr1_data_i (fl_ev),
      .rd_en_i    (deq),
      .rd_data_o  (head_ev),
      .level_o    (evq_level),
      .overflow_o (evq_overflow)
   );

`ifdef OUT_SCHED_TIMEOUT_EN
   logic [31:0] tmo_q;
   logic        rdto_q;
   assign tmo_hit = (state_q == S_RD_WAIT) && (tmo_q == 32'(TIMEOUT_CYC - 1));

   // Watchdog: counts cycles spent in RD_WAIT, flags a missing read_done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q  <= '0;
         rdto_q <= 1'b0;
      end else begin
         tmo_q <= (state_q == S_RD_WAIT) ? tmo_q + 32'd1 : 32'd0;
         if (tmo_hit && !read_done) rdto_q <= 1'b1;
      end
   end
   assign rd_timeout = rdto_q;
`else
   assign tmo_hit    = 1'b0;
   assign rd_timeout = 1'b0;
`endif

   // Next-state logic and FSM-driven strobes
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      seq_d        = seq_q;
      deq          = 1'b0;
      hdr_valid    = 1'b0;
      trigger_read = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (evq_level != '0) begin
               deq     = 1'b1;
               idx_d   = 3'd0;
               state_d = S_HDR;
            end
         end
         S_HDR: begin
            hdr_valid = 1'b1;
            if (hdr_ready) begin
               if (idx_q == HDR_LAST_IDX)
                  state_d = (type_q == EV_FULL) ? S_RD_REQ : S_DONE;
               else
                  idx_d = idx_q + 3'd1;
            end
         end
         S_RD_REQ: begin
            trigger_read = 1'b1;
            state_d      = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (read_done || tmo_hit) state_d = S_DONE;
         end
         S_DONE: begin
            seq_d   = seq_q + 16'd1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, sequence counter and working copy of the dequeued event
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         seq_q   <= '0;
         type_q  <= 1'b0;
         id_q    <= '0;
         lvl_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         seq_q   <= seq_d;
         if (deq) begin
            type_q <= head_ev[EV_W-1];
            id_q   <= head_ev[ID_W-1:0];
            lvl_q  <= evq_level - LVL_W'(1);
         end
      end
   end

   // Header word mux; zero outside HDR so idle outputs read 0
   always_comb begin
      hdr_data = 16'h0000;
      if (state_q == S_HDR) begin
         case (idx_q)
            3'd0:    hdr_data = (type_q == EV_FULL) ? MAGIC_FULL : MAGIC_NOTIF;
            3'd1:    hdr_data = (type_q == EV_FULL) ? TYPE_FULL  : TYPE_NOTIF;
            3'd2:    hdr_data = 16'(id_q);
            3'd3:    hdr_data = seq_q;
            3'd4:    hdr_data = 16'(lvl_q);
            3'd5:    hdr_data = (type_q == EV_FULL) ? FULL_WORDS : 16'h0000;
            default: hdr_data = 16'h0000;
         endcase
      end
   end

   assign hdr_last            = (state_q == S_HDR) && (idx_q == HDR_LAST_IDX);
   assign transmission_active = (state_q != S_IDLE);
   assign rd_bram_start       = 4'd0;
   assign rd_bram_end         = trigger_read ? 4'(NUM_BRAM - 1) : 4'd0;
   assign rd_addr_count       = trigger_read ? 16'(BRAM_DEPTH) : 16'd0;

endmodule

// File: tb/tb_output_packet_scheduler.sv
// Directed bench for output_packet_scheduler with a header-word scoreboard.
module tb_output_packet_scheduler;

   localparam int NUM_BRAM   = 8;
   localparam int BRAM_DEPTH = 512;
   localparam logic [15:0] FULL_WORDS = 16'(NUM_BRAM * BRAM_DEPTH);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        batch_complete = 1'b0;
   logic [2:0]  current_batch_id = '0;
   logic        all_batches_done = 1'b0;
   logic [1:0]  completed_layer_id = '0;
   logic [15:0] hdr_data;
   logic        hdr_valid;
   logic        hdr_ready = 1'b1;
   logic        hdr_last;
   logic        trigger_read;
   logic [3:0]  rd_bram_start, rd_bram_end;
   logic [15:0] rd_addr_count;
   logic        read_done = 1'b0;
   logic        transmission_active;
   logic        evq_overflow;
   logic [2:0]  evq_level;
   logic        rd_timeout;

   output_packet_scheduler #(
      .NUM_BRAM(NUM_BRAM), .BRAM_DEPTH(BRAM_DEPTH), .BATCH_W(3), .LAYER_W(2),
      .EVQ_DEPTH(4), .TIMEOUT_CYC(100)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .batch_complete(batch_complete), .current_batch_id(current_batch_id),
      .all_batches_done(all_batches_done), .completed_layer_id(completed_layer_id),
      .hdr_data(hdr_data), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_last(hdr_last),
      .trigger_read(trigger_read), .rd_bram_start(rd_bram_start), .rd_bram_end(rd_bram_end),
      .rd_addr_count(rd_addr_count), .read_done(read_done),
      .transmission_active(transmission_active), .evq_overflow(evq_overflow),
      .evq_level(evq_level), .rd_timeout(rd_timeout)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int trig_cnt = 0;
   int hv_cnt   = 0;
   logic [15:0] tb_seq = '0;
   logic [16:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Expected header words {last, data} for one packet, using the bench's own seq
   task automatic push_pkt(input logic full, input logic [15:0] id, input logic [15:0] lvl);
      exp_q.push_back({1'b0, full ? 16'hDA7A : 16'hC0DE});
      exp_q.push_back({1'b0, full ? 16'h0002 : 16'h0001});
      exp_q.push_back({1'b0, id});
      exp_q.push_back({1'b0, tb_seq});
      exp_q.push_back({1'b0, lvl});
      exp_q.push_back({1'b1, full ? FULL_WORDS : 16'h0000});
      tb_seq++;
   endtask

   task automatic pulse(input logic b, input logic [2:0] bid, input logic a, input logic [1:0] lid);
      @(posedge clk); #2;
      batch_complete = b; current_batch_id = bid;
      all_batches_done = a; completed_layer_id = lid;
      @(posedge clk); #2;
      batch_complete = 1'b0; all_batches_done = 1'b0;
   endtask

   task automatic pulse_done();
      @(posedge clk); #2; read_done = 1'b1;
      @(posedge clk); #2; read_done = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || transmission_active || evq_level != '0) && n < 600) begin
         @(posedge clk); #1; n++;
      end
      chk(tag, 32'(n < 600), 32'd1);
   endtask

   task automatic wait_trig(input string tag, input int t0);
      int n = 0;
      while (trig_cnt == t0 && n < 300) begin
         @(posedge clk); #1; n++;
      end
      chk(tag, 32'(n < 300), 32'd1);
   endtask

   task automatic wait_hv(input string tag);
      int n = 0;
      while (!hdr_valid && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk(tag, 32'(hdr_valid), 32'd1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_hdr_data"}, 32'(hdr_data), 32'd0);
      chk({tag, "_hdr_valid"}, 32'(hdr_valid), 32'd0);
      chk({tag, "_hdr_last"}, 32'(hdr_last), 32'd0);
      chk({tag, "_trigger"}, 32'(trigger_read), 32'd0);
      chk({tag, "_rd_end"}, 32'(rd_bram_end), 32'd0);
      chk({tag, "_rd_count"}, 32'(rd_addr_count), 32'd0);
      chk({tag, "_active"}, 32'(transmission_active), 32'd0);
      chk({tag, "_ovf"}, 32'(evq_overflow), 32'd0);
      chk({tag, "_level"}, 32'(evq_level), 32'd0);
      chk({tag, "_rd_timeout"}, 32'(rd_timeout), 32'd0);
   endtask

   // Monitor: scoreboard pops on each accepted header word, hold check, read request fields
   initial begin
      logic        stall_q;
      logic [15:0] hold_d;
      logic [16:0] e;
      stall_q = 1'b0;
      hold_d  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_q = 1'b0;
         end else begin
            if (hdr_valid) hv_cnt++;
            if (stall_q && hdr_valid) chk("hdr_hold", 32'(hdr_data), 32'(hold_d));
            stall_q = hdr_valid && !hdr_ready;
            hold_d  = hdr_data;
            if (hdr_valid && hdr_ready) begin
               chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("hdr_data", 32'(hdr_data), 32'(e[15:0]));
                  chk("hdr_last", 32'(hdr_last), 32'(e[16]));
               end
            end
            if (trigger_read) begin
               trig_cnt++;
               chk("rd_start", 32'(rd_bram_start), 32'd0);
               chk("rd_end", 32'(rd_bram_end), 32'(NUM_BRAM - 1));
               chk("rd_count", 32'(rd_addr_count), 32'(BRAM_DEPTH));
            end
         end
      end
   end

   initial begin
      int t0;
      // Reset state
      repeat (3) @(posedge clk);
      #1 check_zero("reset");
      @(posedge clk); #2 rst_n = 1'b1;

      // Single NOTIF, batch 5, ready held high: six consecutive words, no read
      hv_cnt = 0; t0 = trig_cnt;
      push_pkt(1'b0, 16'd5, 16'd0);
      pulse(1'b1, 3'd5, 1'b0, 2'd0);
      wait_idle("notif_idle");
      chk("notif_consecutive", 32'(hv_cnt), 32'd6);
      chk("notif_no_trig", 32'(trig_cnt - t0), 32'd0);

      // Stray read_done while idle is ignored
      pulse_done();
      #1 chk("stray_done_idle", 32'(transmission_active), 32'd0);

      // FULL, layer 2: header, one read request, completion only on read_done
      t0 = trig_cnt;
      push_pkt(1'b1, 16'd2, 16'd0);
      pulse(1'b0, 3'd0, 1'b1, 2'd2);
      wait_trig("full_trig", t0);
      repeat (5) @(posedge clk);
      #1 chk("full_waits_done", 32'(transmission_active), 32'd1);
      chk("full_one_trig", 32'(trig_cnt - t0), 32'd1);
      pulse_done();
      wait_idle("full_idle");

      // Simultaneous NOTIF(3) + FULL(1): NOTIF first, FULL second
      t0 = trig_cnt;
      push_pkt(1'b0, 16'd3, 16'd1);
      push_pkt(1'b1, 16'd1, 16'd0);
      pulse(1'b1, 3'd3, 1'b1, 2'd1);
      wait_trig("simul_trig", t0);
      pulse_done();
      wait_idle("simul_idle");

      // Back-pressure on word 2 for five cycles
      hdr_ready = 1'b0;
      push_pkt(1'b0, 16'd6, 16'd0);
      pulse(1'b1, 3'd6, 1'b0, 2'd0);
      wait_hv("stall_valid");
      hdr_ready = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      hdr_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1 chk("stall_word2", 32'(hdr_data), 32'd6);
      hdr_ready = 1'b1;
      wait_idle("stall_idle");

      // Fill the queue behind a FULL packet stuck in RD_WAIT
      t0 = trig_cnt;
      push_pkt(1'b1, 16'd0, 16'd0);
      pulse(1'b0, 3'd0, 1'b1, 2'd0);
      wait_trig("fill_trig", t0);
      push_pkt(1'b1, 16'd1, 16'd3);
      push_pkt(1'b1, 16'd2, 16'd2);
      push_pkt(1'b1, 16'd3, 16'd1);
      pulse(1'b0, 3'd0, 1'b1, 2'd1);
      pulse(1'b0, 3'd0, 1'b1, 2'd2);
      pulse(1'b0, 3'd0, 1'b1, 2'd3);
      chk("fill_lvl3", 32'(evq_level), 32'd3);
      chk("fill_no_ovf", 32'(evq_overflow), 32'd0);
      // One slot left, both pulses: FULL kept, NOTIF dropped
      push_pkt(1'b1, 16'd0, 16'd0);
      pulse(1'b1, 3'd7, 1'b1, 2'd0);
      chk("one_slot_ovf", 32'(evq_overflow), 32'd1);
      chk("one_slot_lvl", 32'(evq_level), 32'd4);
      pulse(1'b1, 3'd4, 1'b0, 2'd0);
      chk("full_q_lvl", 32'(evq_level), 32'd4);
      chk("busy_active", 32'(transmission_active), 32'd1);
      pulse_done();
      for (int i = 0; i < 4; i++) begin
         t0 = trig_cnt;
         wait_trig("drain_trig", t0);
         pulse_done();
      end
      wait_idle("drain_idle");
      chk("ovf_sticky", 32'(evq_overflow), 32'd1);

      // Reset in the middle of a header aborts the packet
      hdr_ready = 1'b0;
      pulse(1'b1, 3'd1, 1'b0, 2'd0);
      wait_hv("abort_valid");
      rst_n = 1'b0;
      #1 check_zero("midrst");
      exp_q.delete();
      tb_seq = '0;
      hdr_ready = 1'b1;
      @(posedge clk); #2 rst_n = 1'b1;
      push_pkt(1'b0, 16'd2, 16'd0);
      pulse(1'b1, 3'd2, 1'b0, 2'd0);
      wait_idle("post_rst_idle");

`ifdef OUT_SCHED_TIMEOUT_EN
      // Watchdog: no read_done, give up after 100 cycles in RD_WAIT
      t0 = trig_cnt;
      push_pkt(1'b1, 16'd3, 16'd0);
      pulse(1'b0, 3'd0, 1'b1, 2'd3);
      wait_trig("tmo_trig", t0);
      repeat (98) @(posedge clk);
      #1 chk("tmo_not_yet", 32'(rd_timeout), 32'd0);
      chk("tmo_still_wait", 32'(transmission_active), 32'd1);
      repeat (3) @(posedge clk);
      #1 chk("tmo_flag", 32'(rd_timeout), 32'd1);
      chk("tmo_idle", 32'(transmission_active), 32'd0);
      push_pkt(1'b0, 16'd4, 16'd0);
      pulse(1'b1, 3'd4, 1'b0, 2'd0);
      wait_idle("tmo_next_idle");
`endif

      chk("sb_empty_end", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
